hinp_acq_sequencer: RTL and testbench
=====================================

// Module: hinp_acq_sequencer
// PURPOSE
//  Synthesizable, parametrised successor to the bench-only HINP drive sequence.
//  Per event: force-reset the CFDs, arm global_cfd_en for a TVC window (1us/4us
//  mode), fire common_stop with veto_rst, then clock out a programmable number
//  of channels on acq_clk. Sits between the DAQ controller and the HINP4 chip
//  pins. Adds a start/busy/done handshake, abort, and free-running (continuous) mode.
// PARAMETERS
//  N_CHAN      16    max channels per readout burst
//  CNT_W       16    width of the shared interval counter
//  T_FRST      10    force_rst high time (cycles)
//  T_SETTLE    10    force_rst fall -> global_cfd_en rise
//  T_WIN_4U    1140  CFD armed window, tvc_mode=1
//  T_WIN_1U    1110  CFD armed window, tvc_mode=0
//  T_VETO      20    common_stop rise -> veto_rst rise
//  T_STOP      500   common_stop high time, measured from its rise
//  T_ACQ_HI    80    acq_clk high time
//  T_ACQ_LO    80    acq_clk low time
// PORTS
//  clk          in   1   system clock
//  dig_rst      in   1   asynchronous, active-high reset
//  start        in   1   1-cycle request; sampled only in IDLE
//  abort        in   1   return to IDLE from any state
//  cont         in   1   1 = re-arm automatically after each readout
//  tvc_mode     in   1   1 = 4us window, 0 = 1us; latched on start
//  rd_chans     in   $clog2(N_CHAN+1)  channels to read; latched on start
//  busy         out  1   high from the cycle after start until return to IDLE
//  done         out  1   1-cycle pulse at end of each readout
//  force_rst, global_cfd_en, common_stop, veto_rst, acq_clk  out 1  chip pins
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0. Outputs are registered.
//  FSM: IDLE -> FRST -> SETTLE -> ARMED -> STOP -> READ -> REARM -> IDLE|FRST.
//   IDLE:   start=1 latches tvc_mode and rd_chans (clamped to N_CHAN); FRST next cycle.
//   FRST:   force_rst=1 for T_FRST cycles.
//   SETTLE: all pins 0 for T_SETTLE cycles.
//   ARMED:  global_cfd_en=1 for T_WIN_4U or T_WIN_1U cycles.
//   STOP:   common_stop=1 and cfd_en=0 in the same cycle. veto_rst=1 from
//           T_VETO cycles after the stop rise. Leave after T_STOP cycles; common_stop drops.
//   READ:   rd_chans pulses on acq_clk, each T_ACQ_HI high then T_ACQ_LO low.
//           Burst starts high. rd_chans=0 skips READ entirely.
//   REARM:  veto_rst drops on entry. done=1 for exactly one cycle.
//           If cont=1: go to FRST with the latched settings. Otherwise go to IDLE.
//  Interval parameter of 0 is treated as 1 cycle. Elaboration error if any
//   T_* >= 2**CNT_W or T_VETO >= T_STOP.
//  Boundary rules:
//   - start while busy: ignored.
//   - abort, any state: next cycle all pins 0, busy 0, no done pulse; abort wins over start.
//   - cont deasserted mid-event: the current event completes, then the FSM goes to IDLE.
//   - dig_rst mid-burst: pins clear immediately (async); no partial pulse extension.
//   - tvc_mode/rd_chans changes while busy: no effect until the next start.
// STRUCTURE
//  Package hinp_pkg: state enum, default T_* constants, clamp function for rd_chans.
//  One sub-module, hinp_interval_cnt: loadable down-counter with zero flag, reused
//   for every state interval and for the acq_clk phase timer. The channel count
//   uses a separate small counter.
// TESTING  (bench overrides: T_FRST=2, T_SETTLE=2, T_WIN_*=8/5, T_VETO=2,
//           T_STOP=6, T_ACQ_*=2)
//  1 Reset, then start with tvc_mode=1, rd_chans=4 -> force_rst high 2 cycles,
//    cfd_en high 8, common_stop high 6, veto_rst rising 2 cycles after stop,
//    4 acq_clk pulses, one done pulse, busy low afterwards.
//  2 tvc_mode=0, rd_chans=0 -> cfd_en window is 5 cycles, no acq_clk edges,
//    done is asserted right after STOP.
//  3 cont=1, rd_chans=16 -> back-to-back events, 16 acq_clk pulses each. Drop
//    cont during event 2 -> exactly 2 done pulses, then IDLE.
//  4 abort during ARMED and abort during the 3rd acq_clk pulse -> all pins 0 next
//    cycle, no done; a following start runs a clean event.
//  5 rd_chans=20 with N_CHAN=16 -> 16 pulses. A start pulse while busy has no
//    effect on the timing.
//  6 dig_rst asserted mid-STOP -> common_stop and veto_rst drop asynchronously,
//    FSM=IDLE.

Source files
------------

// File: rtl/hinp_pkg.sv
// Shared types, default timing constants and small helpers for the HINP acquisition sequencer.
package hinp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRST,
        S_SETTLE,
        S_ARMED,
        S_STOP,
        S_READ,
        S_REARM
    } state_e;

    localparam int DEF_N_CHAN   = 16;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_T_FRST   = 10;
    localparam int DEF_T_SETTLE = 10;
    localparam int DEF_T_WIN_4U = 1140;
    localparam int DEF_T_WIN_1U = 1110;
    localparam int DEF_T_VETO   = 20;
    localparam int DEF_T_STOP   = 500;
    localparam int DEF_T_ACQ_HI = 80;
    localparam int DEF_T_ACQ_LO = 80;

    // A zero-length interval still occupies one cycle.
    function automatic int eff_t(input int t);
        return (t < 1) ? 1 : t;
    endfunction

    function automatic int clamp_chans(input int req, input int max_ch);
        return (req > max_ch) ? max_ch : req;
    endfunction

endpackage

// File: rtl/hinp_acq_sequencer_if.sv
// DAQ-controller / chip-pin bundle of the sequencer; master = DAQ side, slave = sequencer.
interface hinp_acq_sequencer_if #(
    parameter int N_CHAN = 16
);
    localparam int RD_W = $clog2(N_CHAN + 1);

    logic            start;
    logic            abort;
    logic            cont;
    logic            tvc_mode;
    logic [RD_W-1:0] rd_chans;
    logic            busy;
    logic            done;
    logic            force_rst;
    logic            global_cfd_en;
    logic            common_stop;
    logic            veto_rst;
    logic            acq_clk;

    modport master (
        output start, abort, cont, tvc_mode, rd_chans,
        input  busy, done, force_rst, global_cfd_en, common_stop, veto_rst, acq_clk
    );

    modport slave (
        input  start, abort, cont, tvc_mode, rd_chans,
        output busy, done, force_rst, global_cfd_en, common_stop, veto_rst, acq_clk
    );
endinterface

// File: rtl/hinp_interval_cnt.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module hinp_interval_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/hinp_acq_sequencer.sv
// HINP event sequencer: force-reset, CFD window, common stop/veto, then an acq_clk readout burst.
module hinp_acq_sequencer
    import hinp_pkg::*;
#(
    parameter int N_CHAN   = DEF_N_CHAN,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int T_FRST   = DEF_T_FRST,
    parameter int T_SETTLE = DEF_T_SETTLE,
    parameter int T_WIN_4U = DEF_T_WIN_4U,
    parameter int T_WIN_1U = DEF_T_WIN_1U,
    parameter int T_VETO   = DEF_T_VETO,
    parameter int T_STOP   = DEF_T_STOP,
    parameter int T_ACQ_HI = DEF_T_ACQ_HI,
    parameter int T_ACQ_LO = DEF_T_ACQ_LO
) (
    input logic                 clk,
    input logic                 dig_rst,
    hinp_acq_sequencer_if.slave bus
);
    localparam int RD_W = $clog2(N_CHAN + 1);

    if (T_FRST >= 2**CNT_W || T_SETTLE >= 2**CNT_W || T_WIN_4U >= 2**CNT_W ||
        T_WIN_1U >= 2**CNT_W || T_VETO >= 2**CNT_W || T_STOP >= 2**CNT_W ||
        T_ACQ_HI >= 2**CNT_W || T_ACQ_LO >= 2**CNT_W || T_VETO >= T_STOP) begin : g_param_err
        $error("hinp_acq_sequencer: interval parameter out of range");
    end

    // Reload values are interval-1 because the counter spends one cycle on each value down to 0.
    localparam logic [CNT_W-1:0] L_FRST    = CNT_W'(eff_t(T_FRST) - 1);
    localparam logic [CNT_W-1:0] L_SETTLE  = CNT_W'(eff_t(T_SETTLE) - 1);
    localparam logic [CNT_W-1:0] L_WIN_4U  = CNT_W'(eff_t(T_WIN_4U) - 1);
    localparam logic [CNT_W-1:0] L_WIN_1U  = CNT_W'(eff_t(T_WIN_1U) - 1);
    localparam logic [CNT_W-1:0] L_STOP    = CNT_W'(eff_t(T_STOP) - 1);
    localparam logic [CNT_W-1:0] L_ACQ_HI  = CNT_W'(eff_t(T_ACQ_HI) - 1);
    localparam logic [CNT_W-1:0] L_ACQ_LO  = CNT_W'(eff_t(T_ACQ_LO) - 1);
    localparam logic [CNT_W-1:0] L_VETO_AT = CNT_W'(eff_t(T_STOP) - eff_t(T_VETO));

    state_e          state_q;
    logic            tvc_q;
    logic [RD_W-1:0] rd_q, ch_q;
    logic            busy_q, done_q, frst_q, cfd_q, stop_q, veto_q, acq_q;
    logic            cnt_load;
    logic [CNT_W-1:0] cnt_val, cnt;
    logic            cnt_zero;

    hinp_interval_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst       (dig_rst),
        .load_i    (cnt_load),
        .load_val_i(cnt_val),
        .cnt_o     (cnt),
        .zero_o    (cnt_zero)
    );

    // Reload the interval counter on every transition the FSM below takes.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        if (bus.abort) begin
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                S_IDLE:   if (bus.start) begin cnt_load = 1'b1; cnt_val = L_FRST; end
                S_FRST:   if (cnt_zero) begin cnt_load = 1'b1; cnt_val = L_SETTLE; end
                S_SETTLE: if (cnt_zero) begin cnt_load = 1'b1; cnt_val = tvc_q ? L_WIN_4U : L_WIN_1U; end
                S_ARMED:  if (cnt_zero) begin cnt_load = 1'b1; cnt_val = L_STOP; end
                S_STOP:   if (cnt_zero) begin cnt_load = 1'b1; cnt_val = (rd_q != '0) ? L_ACQ_HI : '0; end
                S_READ: if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = acq_q ? L_ACQ_LO : ((ch_q == RD_W'(1)) ? '0 : L_ACQ_HI);
                end
                S_REARM: begin cnt_load = 1'b1; cnt_val = bus.cont ? L_FRST : '0; end
                default:  cnt_load = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge dig_rst) begin
        if (dig_rst) begin
            state_q <= S_IDLE;
            tvc_q   <= 1'b0;
            rd_q    <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            frst_q  <= 1'b0;
            cfd_q   <= 1'b0;
            stop_q  <= 1'b0;
            veto_q  <= 1'b0;
            acq_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                frst_q  <= 1'b0;
                cfd_q   <= 1'b0;
                stop_q  <= 1'b0;
                veto_q  <= 1'b0;
                acq_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (bus.start) begin
                        tvc_q   <= bus.tvc_mode;
                        rd_q    <= RD_W'(clamp_chans(int'(bus.rd_chans), N_CHAN));
                        busy_q  <= 1'b1;
                        frst_q  <= 1'b1;
                        state_q <= S_FRST;
                    end
                    S_FRST: if (cnt_zero) begin
                        frst_q  <= 1'b0;
                        state_q <= S_SETTLE;
                    end
                    S_SETTLE: if (cnt_zero) begin
                        cfd_q   <= 1'b1;
                        state_q <= S_ARMED;
                    end
                    S_ARMED: if (cnt_zero) begin
                        cfd_q   <= 1'b0;
                        stop_q  <= 1'b1;
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        if (cnt_zero) begin
                            stop_q <= 1'b0;
                            if (rd_q == '0) begin
                                veto_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_REARM;
                            end else begin
                                veto_q  <= 1'b1;
                                acq_q   <= 1'b1;
                                ch_q    <= rd_q;
                                state_q <= S_READ;
                            end
                        end else if (cnt == L_VETO_AT) begin
                            veto_q <= 1'b1;
                        end
                    end
                    // ch_q counts pulses still owed, including the one in flight.
                    S_READ: if (cnt_zero) begin
                        if (acq_q) begin
                            acq_q <= 1'b0;
                        end else if (ch_q == RD_W'(1)) begin
                            veto_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_REARM;
                        end else begin
                            ch_q  <= ch_q - RD_W'(1);
                            acq_q <= 1'b1;
                        end
                    end
                    S_REARM: begin
                        if (bus.cont) begin
                            frst_q  <= 1'b1;
                            state_q <= S_FRST;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.force_rst     = frst_q;
    assign bus.global_cfd_en = cfd_q;
    assign bus.common_stop   = stop_q;
    assign bus.veto_rst      = veto_q;
    assign bus.acq_clk       = acq_q;
endmodule

// File: tb/tb_hinp_acq_sequencer.sv
// Scoreboard bench for hinp_acq_sequencer with shortened intervals; one record per expected done pulse.
module tb_hinp_acq_sequencer;
    localparam int N_CHAN = 16;

    logic clk = 1'b0;
    logic dig_rst;
    always #5 clk = ~clk;

    hinp_acq_sequencer_if #(.N_CHAN(N_CHAN)) bus ();

    hinp_acq_sequencer #(
        .N_CHAN(N_CHAN), .CNT_W(16), .T_FRST(2), .T_SETTLE(2), .T_WIN_4U(8), .T_WIN_1U(5),
        .T_VETO(2), .T_STOP(6), .T_ACQ_HI(2), .T_ACQ_LO(2)
    ) dut (
        .clk    (clk),
        .dig_rst(dig_rst),
        .bus    (bus)
    );

    typedef struct {
        int frst; int win; int stop; int vdly; int pulses; int acqhi; int gap;
    } ev_t;

    ev_t sb[$];
    ev_t ev;
    int  checks = 0;
    int  failures = 0;
    int  done_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Hand-derived per-event expectations: frst 2, stop 6, veto 2 after stop, 4 cycles per pulse.
    task automatic push_ev(input int win, input int pulses);
        ev_t e;
        e.frst = 2; e.win = win; e.stop = 6; e.vdly = 2;
        e.pulses = pulses; e.acqhi = pulses * 2; e.gap = pulses * 4;
        sb.push_back(e);
    endtask

    function automatic int pins();
        return int'({bus.busy, bus.done, bus.force_rst, bus.global_cfd_en,
                     bus.common_stop, bus.veto_rst, bus.acq_clk});
    endfunction

    // Monitor: measure each event's pin timing, compare against the scoreboard on done.
    logic p_frst = 0, p_stop = 0, p_veto = 0, p_acq = 0;
    int m_frst, m_cfd, m_stop, m_vdly, m_pulses, m_acqhi;
    int since_rise = 0, since_fall = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (dig_rst) begin
                p_frst = 0; p_stop = 0; p_veto = 0; p_acq = 0;
                m_frst = 0; m_cfd = 0; m_stop = 0; m_vdly = -1; m_pulses = 0; m_acqhi = 0;
            end else begin
                if (bus.force_rst && !p_frst) begin
                    m_frst = 0; m_cfd = 0; m_stop = 0; m_vdly = -1; m_pulses = 0; m_acqhi = 0;
                end
                if (bus.force_rst) m_frst++;
                if (bus.global_cfd_en) m_cfd++;
                if (bus.common_stop) m_stop++;
                if (bus.common_stop && !p_stop) since_rise = 0; else since_rise++;
                if (!bus.common_stop && p_stop) since_fall = 0; else since_fall++;
                if (bus.veto_rst && !p_veto) m_vdly = since_rise;
                if (bus.acq_clk && !p_acq) m_pulses++;
                if (bus.acq_clk) m_acqhi++;
                if (bus.done) begin
                    done_cnt++;
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        ev = sb.pop_front();
                        chk("frst_width", m_frst, ev.frst);
                        chk("cfd_window", m_cfd, ev.win);
                        chk("stop_width", m_stop, ev.stop);
                        chk("veto_delay", m_vdly, ev.vdly);
                        chk("acq_pulses", m_pulses, ev.pulses);
                        chk("acq_high_cycles", m_acqhi, ev.acqhi);
                        chk("stop_to_done", since_fall, ev.gap);
                    end
                end
                p_frst = bus.force_rst; p_stop = bus.common_stop;
                p_veto = bus.veto_rst;  p_acq = bus.acq_clk;
            end
        end
    end

    // Start pulse, then scramble the inputs that must have been latched.
    task automatic start_ev(input logic tvc, input int rd);
        @(negedge clk);
        bus.tvc_mode = tvc; bus.rd_chans = 5'(rd); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.tvc_mode = ~tvc; bus.rd_chans = 5'd7;
        chk("busy_after_start", int'(bus.busy), 1);
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit seen = 0;
        for (int n = 0; n < max_cyc && !seen; n++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        chk(tag, int'(seen), 1);
    endtask

    task automatic wait_high(input string tag, input int which, input int max_cyc);
        bit seen = 0;
        for (int n = 0; n < max_cyc && !seen; n++) begin
            @(negedge clk);
            if (which == 0 && bus.global_cfd_en) seen = 1;
            if (which == 1 && bus.veto_rst) seen = 1;
        end
        chk(tag, int'(seen), 1);
    endtask

    int d0;
    int rises;
    logic pa;

    initial begin
        bus.start = 0; bus.abort = 0; bus.cont = 0; bus.tvc_mode = 0; bus.rd_chans = '0;
        dig_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", pins(), 0);
        dig_rst = 1'b0;

        // 1: 4us window, 4 channels
        push_ev(8, 4);
        start_ev(1'b1, 4);
        wait_done("t1_done_seen", 200);
        @(negedge clk);
        chk("t1_busy_low", int'(bus.busy), 0);

        // 2: 1us window, no readout
        push_ev(5, 0);
        start_ev(1'b0, 0);
        wait_done("t2_done_seen", 200);
        @(negedge clk);
        chk("t2_busy_low", int'(bus.busy), 0);

        // 3: continuous mode, cont dropped during the second event
        d0 = done_cnt;
        bus.cont = 1'b1;
        push_ev(8, 16);
        push_ev(8, 16);
        start_ev(1'b1, 16);
        wait_done("t3_ev1_done_seen", 300);
        repeat (10) @(negedge clk);
        bus.cont = 1'b0;
        wait_done("t3_ev2_done_seen", 300);
        repeat (20) @(negedge clk);
        chk("t3_done_count", done_cnt - d0, 2);
        chk("t3_idle_pins", pins(), 0);

        // 4a: abort in ARMED, then abort+start together in IDLE
        d0 = done_cnt;
        start_ev(1'b1, 4);
        wait_high("t4a_armed_seen", 0, 50);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("t4a_pins_after_abort", pins(), 0);
        bus.abort = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; bus.start = 1'b0;
        repeat (30) @(negedge clk);
        chk("t4a_abort_beats_start", pins(), 0);
        chk("t4a_no_done", done_cnt - d0, 0);

        // 4b: abort during the third acq_clk pulse, then a clean event
        start_ev(1'b1, 4);
        rises = 0; pa = 1'b0;
        for (int n = 0; n < 200 && rises < 3; n++) begin
            @(negedge clk);
            if (bus.acq_clk && !pa) rises++;
            pa = bus.acq_clk;
        end
        chk("t4b_third_pulse_seen", rises, 3);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("t4b_pins_after_abort", pins(), 0);
        repeat (20) @(negedge clk);
        chk("t4b_no_done", done_cnt - d0, 0);
        push_ev(8, 4);
        start_ev(1'b1, 4);
        wait_done("t4b_clean_done_seen", 200);

        // 5: rd_chans clamped to N_CHAN; start while busy ignored
        repeat (3) @(negedge clk);
        push_ev(8, 16);
        start_ev(1'b1, 20);
        wait_high("t5_armed_seen", 0, 50);
        bus.tvc_mode = 1'b0; bus.rd_chans = 5'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("t5_done_seen", 300);
        @(negedge clk);
        chk("t5_busy_low", int'(bus.busy), 0);

        // 6: asynchronous reset in the middle of STOP
        d0 = done_cnt;
        start_ev(1'b1, 4);
        wait_high("t6_veto_seen", 1, 100);
        #1 dig_rst = 1'b1;
        #1 chk("t6_stop_veto_async_clear", int'({bus.common_stop, bus.veto_rst}), 0);
        chk("t6_pins_async_clear", pins(), 0);
        @(negedge clk);
        dig_rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_stays_idle", pins(), 0);
        chk("t6_no_done", done_cnt - d0, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=1 required=0");
        $fatal(1, "timeout");
    end
endmodule
